swap_regfile: RTL and testbench
===============================

# swap_regfile

Three-register datapath that executes the bus transfers commanded by the swap control FSM. Each register can drive a shared internal bus (`h1..h3`) and capture from it (`c1..c3`); a correct three-step sequence exchanges the contents of R1 and R2 through R3. The block also provides an external load/read port, transfer accounting and bus-contention checking. It sits directly below the swap controller and owns all data storage for the swap function.

## Interface

- `N`, 8, register and bus width in bits
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `h1`, `h2`, `h3`  in  1 each  drive enable: register Ri drives the bus this cycle
- `c1`, `c2`, `c3`  in  1 each  capture enable: register Ri loads the bus at the next edge
- `done`  in  1  controller completion strobe
- `ext_wr`  in  1  external write request
- `ext_sel`  in  2  external write target: 1=R1, 2=R2, 3=R3, 0=ignored
- `ext_data`  in  N  external write data
- `rd_sel`  in  2  read select: 0=bus, 1=R1, 2=R2, 3=R3
- `rd_data`  out  N  combinational read of the selected source
- `bus`  out  N  current internal bus value
- `xfer_cnt`  out  8  count of valid transfer cycles, saturating
- `swapped`  out  1  sticky: a `done` has been seen since the last external write
- `wr_drop`  out  1  one-cycle pulse: an `ext_wr` was discarded
- `conflict`  out  1  sticky bus-contention flag

## Operation

- Drive count D = number of asserted `h1..h3`.
- Bus value:
  - D=0: 0.
  - D=1: the driving register.
  - D>1: see Configuration.
- Valid transfer cycle: D=1 and at least one `c` asserted.
  - Every register with its `c` asserted loads `bus` at the edge.
  - A register may drive and capture in the same cycle; its value is unchanged.
  - Several registers may capture the same bus value.
- `c` asserted with D=0: no capture, no flag change.
- `xfer_cnt` increments on each valid transfer cycle and saturates at 255.
- External write: `ext_wr`=1 with `ext_sel`≠0 loads `ext_data` into the selected register at the edge.
  - If any of `h1..h3`/`c1..c3` is asserted in the same cycle, the write is discarded and `wr_drop`=1 in the following cycle.
  - An accepted write clears `swapped`.
  - `ext_wr` with `ext_sel`=0 is ignored and produces no `wr_drop`.
- `done`=1 sets `swapped` at the edge. It has no effect on the registers. If `done` and an accepted `ext_wr` occur in the same cycle, `swapped` ends at 1 (set wins).
- Reset (`rst`=1 at the edge, any point in a sequence):
  - R1, R2, R3 = 0.
  - `xfer_cnt`=0, `swapped`=0, `wr_drop`=0, `conflict`=0.
  - Reset overrides every concurrent command. Partial swaps are not completed.
- `bus` and `rd_data` are 0 after reset until a drive or write occurs.

## Timing

- Transfer latency is one cycle: controls are sampled at edge k, and the captured value is visible on the register/`rd_data` after edge k.
- `bus` and `rd_data` are combinational from the current controls and registers.
- A full swap takes 3 consecutive transfer cycles plus `done`:
  - R1→R3: `h1`,`c3`
  - R2→R1: `h2`,`c1`
  - R3→R2: `h3`,`c2`
- Back-to-back transfers are supported: each cycle sees the values committed by the previous one.
- `wr_drop` is high for exactly one cycle per discarded write.
- `xfer_cnt`, `swapped` and `conflict` update at the same edge as the triggering event.

## Configuration

- `SWAP_CHECK_EN` defined (checking build):
  - D>1 forces `bus`=0 and suppresses all captures that cycle.
  - `xfer_cnt` is not incremented.
  - `conflict` is set and stays set until `rst`.
- `SWAP_CHECK_EN` undefined:
  - D>1 gives `bus` = bitwise OR of all driving registers.
  - Captures proceed and the cycle counts as a valid transfer.
  - `conflict` is tied to 0.

## Test plan

- Write R1=0x0A and R2=0x05. Run R1→R3, R2→R1, R3→R2, then `done` → R1=0x05, R2=0x0A, R3=0x0A, `xfer_cnt`=3, `swapped`=1, `conflict`=0.
- With `SWAP_CHECK_EN`, R1=0x0A, R2=0x05, R3=0x00: assert `h1`,`h2`,`c3` for one cycle → R3=0x00, `bus`=0 during that cycle, `conflict`=1 and held; `xfer_cnt` unchanged. Without the macro, the same stimulus gives R3=0x0F and `conflict`=0.
- `ext_wr`, `ext_sel`=2, `ext_data`=0x33 in the same cycle as `h1`,`c3` → R2 unchanged, R3 receives R1, `wr_drop`=1 for one cycle. The same write one cycle later → R2=0x33, `swapped` cleared.
- Assert `rst` after the second step of a swap → all registers 0, `xfer_cnt`=0, `swapped`=0 on the next cycle; a following `h3`,`c2` loads 0 into R2.
- Issue 300 valid transfer cycles → `xfer_cnt` stops at 255 and does not wrap.
- `rd_sel`=0 while `h2` is asserted with R2=0x5A → `rd_data`=0x5A in the same cycle; `c1` alone with D=0 → R1 unchanged.

Source files
------------

// File: rtl/swap_regfile.sv
// rtl/swap_regfile.sv - three-register swap datapath with shared bus, external port and transfer accounting
// Optional build macro SWAP_CHECK_EN: multi-driver cycles are blocked and flagged instead of OR-merged.
module swap_regfile #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         h1_i,
    input  logic         h2_i,
    input  logic         h3_i,
    input  logic         c1_i,
    input  logic         c2_i,
    input  logic         c3_i,
    input  logic         done_i,
    input  logic         ext_wr_i,
    input  logic [1:0]   ext_sel_i,
    input  logic [N-1:0] ext_data_i,
    input  logic [1:0]   rd_sel_i,
    output logic [N-1:0] rd_data_o,
    output logic [N-1:0] bus_o,
    output logic [7:0]   xfer_cnt_o,
    output logic         swapped_o,
    output logic         wr_drop_o,
    output logic         conflict_o
);

    logic [N-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         swapped_q, swapped_d;
    logic         wr_drop_q, wr_drop_d;
    logic [1:0]   drive_cnt;
    logic [N-1:0] bus_or;
    logic         any_c, any_ctrl, cap_en, xfer_valid;
    logic         ext_hit, wr_ok, wr_dropped;

    assign drive_cnt = {1'b0, h1_i} + {1'b0, h2_i} + {1'b0, h3_i};
    // With a single driver the OR reduces to that register's value.
    assign bus_or    = ({N{h1_i}} & r1_q) | ({N{h2_i}} & r2_q) | ({N{h3_i}} & r3_q);
    assign any_c     = c1_i | c2_i | c3_i;
    assign any_ctrl  = any_c | h1_i | h2_i | h3_i;

`ifdef SWAP_CHECK_EN
    logic multi_drive;
    logic conflict_q, conflict_d;

    assign multi_drive = (drive_cnt > 2'd1);
    assign bus_o       = multi_drive ? '0 : bus_or;
    assign cap_en      = (drive_cnt == 2'd1);
    assign conflict_d  = conflict_q | multi_drive;
    assign conflict_o  = conflict_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end
`else
    assign bus_o      = bus_or;
    assign cap_en     = (drive_cnt != 2'd0);
    assign conflict_o = 1'b0;
`endif

    assign xfer_valid = cap_en & any_c;
    assign ext_hit    = ext_wr_i & (ext_sel_i != 2'd0);
    assign wr_ok      = ext_hit & ~any_ctrl;
    assign wr_dropped = ext_hit & any_ctrl;

    always_comb begin
        r1_d      = r1_q;
        r2_d      = r2_q;
        r3_d      = r3_q;
        cnt_d     = cnt_q;
        swapped_d = swapped_q;
        wr_drop_d = wr_dropped;
        if (xfer_valid) begin
            if (c1_i) r1_d = bus_o;
            if (c2_i) r2_d = bus_o;
            if (c3_i) r3_d = bus_o;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
        // An accepted write implies no capture is active, so the two never collide.
        if (wr_ok) begin
            case (ext_sel_i)
                2'd1:    r1_d = ext_data_i;
                2'd2:    r2_d = ext_data_i;
                2'd3:    r3_d = ext_data_i;
                default: ;
            endcase
            swapped_d = 1'b0;
        end
        if (done_i) swapped_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r1_q      <= '0;
            r2_q      <= '0;
            r3_q      <= '0;
            cnt_q     <= '0;
            swapped_q <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            r3_q      <= r3_d;
            cnt_q     <= cnt_d;
            swapped_q <= swapped_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        rd_data_o = bus_o;
        case (rd_sel_i)
            2'd1:    rd_data_o = r1_q;
            2'd2:    rd_data_o = r2_q;
            2'd3:    rd_data_o = r3_q;
            default: rd_data_o = bus_o;
        endcase
    end

    assign xfer_cnt_o = cnt_q;
    assign swapped_o  = swapped_q;
    assign wr_drop_o  = wr_drop_q;

endmodule

// File: tb/tb_swap_regfile.sv
// tb/tb_swap_regfile.sv - scoreboard bench for swap_regfile with a behavioural reference model
module tb_swap_regfile;

`ifdef SWAP_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       h1 = 0, h2 = 0, h3 = 0, c1 = 0, c2 = 0, c3 = 0, done = 0, ext_wr = 0;
    logic [1:0] ext_sel = 0, rd_sel = 0;
    logic [7:0] ext_data = 0;
    logic [7:0] rd_data, bus, xfer_cnt;
    logic       swapped, wr_drop, conflict;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       sw;
        logic       drop;
        logic       conf;
    } st_t;

    typedef struct {
        logic [7:0] bus;
        logic [7:0] rd;
    } cb_t;

    st_t state_q[$];
    cb_t comb_q[$];
    st_t pend;
    bit  have_pend = 0;

    logic [7:0] m_r[1:3];
    int         m_cnt = 0;
    logic       m_sw = 0, m_drop = 0, m_conf = 0;

    swap_regfile #(.N(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .h1_i(h1), .h2_i(h2), .h3_i(h3),
        .c1_i(c1), .c2_i(c2), .c3_i(c3),
        .done_i(done), .ext_wr_i(ext_wr), .ext_sel_i(ext_sel), .ext_data_i(ext_data),
        .rd_sel_i(rd_sel), .rd_data_o(rd_data), .bus_o(bus), .xfer_cnt_o(xfer_cnt),
        .swapped_o(swapped), .wr_drop_o(wr_drop), .conflict_o(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is advanced from the stated rules, not the RTL structure.
    task automatic cycle(input bit r, input bit [3:1] h, input bit [3:1] c, input bit dn,
                         input bit ew, input bit [1:0] es, input bit [7:0] ed, input bit [1:0] rs);
        int         d;
        logic [7:0] bv;
        bit         valid, ctrl, hit;
        cb_t        cb;
        @(posedge clk);
        #1;
        if (have_pend) state_q.push_back(pend);
        rst = r; h1 = h[1]; h2 = h[2]; h3 = h[3]; c1 = c[1]; c2 = c[2]; c3 = c[3];
        done = dn; ext_wr = ew; ext_sel = es; ext_data = ed; rd_sel = rs;

        d  = 0;
        bv = 8'h00;
        for (int i = 1; i <= 3; i++) begin
            if (h[i]) begin
                d++;
                bv = bv | m_r[i];
            end
        end
        if (CHECK && d > 1) bv = 8'h00;
        cb.bus = bv;
        cb.rd  = (rs == 0) ? bv : m_r[rs];
        comb_q.push_back(cb);

        valid = (c != 0) && (d == 1 || (d > 1 && !CHECK));
        ctrl  = (h != 0) || (c != 0);
        hit   = ew && (es != 0);
        if (r) begin
            for (int i = 1; i <= 3; i++) m_r[i] = 8'h00;
            m_cnt = 0; m_sw = 0; m_drop = 0; m_conf = 0;
        end else begin
            if (valid) begin
                for (int i = 1; i <= 3; i++) if (c[i]) m_r[i] = bv;
                if (m_cnt < 255) m_cnt++;
            end
            if (hit && !ctrl) begin
                m_r[es] = ed;
                m_sw    = 0;
            end
            if (dn) m_sw = 1;
            m_drop = hit && ctrl;
            if (CHECK && d > 1) m_conf = 1;
        end
        pend.cnt  = 8'(m_cnt);
        pend.sw   = m_sw;
        pend.drop = m_drop;
        pend.conf = m_conf;
        have_pend = 1;
    endtask

    task automatic idle(input bit [1:0] rs);
        cycle(0, 3'b000, 3'b000, 0, 0, 2'd0, 8'h00, rs);
    endtask

    task automatic wr(input bit [1:0] es, input bit [7:0] ed);
        cycle(0, 3'b000, 3'b000, 0, 1, es, ed, 2'd0);
    endtask

    initial begin : monitor
        st_t s;
        cb_t cb;
        forever begin
            @(negedge clk);
            if (state_q.size() > 0) begin
                s = state_q.pop_front();
                chk("sb_xfer_cnt", xfer_cnt, s.cnt);
                chk("sb_swapped", {7'd0, swapped}, {7'd0, s.sw});
                chk("sb_wr_drop", {7'd0, wr_drop}, {7'd0, s.drop});
                chk("sb_conflict", {7'd0, conflict}, {7'd0, s.conf});
            end
            if (comb_q.size() > 0) begin
                cb = comb_q.pop_front();
                chk("sb_bus", bus, cb.bus);
                chk("sb_rd_data", rd_data, cb.rd);
            end
        end
    end

    initial begin : stim
        for (int i = 1; i <= 3; i++) m_r[i] = 8'h00;

        // Full swap through R3
        cycle(1, 3'b000, 3'b000, 0, 0, 2'd0, 8'h00, 2'd0);
        wr(2'd1, 8'h0A);
        wr(2'd2, 8'h05);
        cycle(0, 3'b001, 3'b100, 0, 0, 2'd0, 8'h00, 2'd0);
        cycle(0, 3'b010, 3'b001, 0, 0, 2'd0, 8'h00, 2'd0);
        cycle(0, 3'b100, 3'b010, 0, 0, 2'd0, 8'h00, 2'd0);
        cycle(0, 3'b000, 3'b000, 1, 0, 2'd0, 8'h00, 2'd0);
        idle(2'd1);
        @(negedge clk);
        chk("swap_r1", rd_data, 8'h05);
        chk("swap_cnt", xfer_cnt, 8'd3);
        chk("swap_flag", {7'd0, swapped}, 8'd1);
        chk("swap_conflict", {7'd0, conflict}, 8'd0);
        idle(2'd2);
        @(negedge clk);
        chk("swap_r2", rd_data, 8'h0A);
        idle(2'd3);
        @(negedge clk);
        chk("swap_r3", rd_data, 8'h0A);

        // Two drivers at once
        cycle(1, 3'b000, 3'b000, 0, 0, 2'd0, 8'h00, 2'd0);
        wr(2'd1, 8'h0A);
        wr(2'd2, 8'h05);
        cycle(0, 3'b011, 3'b100, 0, 0, 2'd0, 8'h00, 2'd0);
        @(negedge clk);
        chk("multi_bus", bus, CHECK ? 8'h00 : 8'h0F);
        idle(2'd3);
        @(negedge clk);
        chk("multi_r3", rd_data, CHECK ? 8'h00 : 8'h0F);
        chk("multi_conflict", {7'd0, conflict}, CHECK ? 8'd1 : 8'd0);
        chk("multi_cnt", xfer_cnt, CHECK ? 8'd0 : 8'd1);
        idle(2'd0);
        @(negedge clk);
        chk("multi_conflict_hold", {7'd0, conflict}, CHECK ? 8'd1 : 8'd0);

        // Write colliding with a transfer is dropped, retry lands
        cycle(1, 3'b000, 3'b000, 0, 0, 2'd0, 8'h00, 2'd0);
        wr(2'd1, 8'h11);
        cycle(0, 3'b000, 3'b000, 1, 0, 2'd0, 8'h00, 2'd0);
        cycle(0, 3'b001, 3'b100, 0, 1, 2'd2, 8'h33, 2'd0);
        wr(2'd2, 8'h33);
        @(negedge clk);
        chk("drop_pulse", {7'd0, wr_drop}, 8'd1);
        chk("drop_swapped_kept", {7'd0, swapped}, 8'd1);
        idle(2'd2);
        @(negedge clk);
        chk("drop_retry_r2", rd_data, 8'h33);
        chk("drop_pulse_end", {7'd0, wr_drop}, 8'd0);
        chk("drop_swapped_clr", {7'd0, swapped}, 8'd0);
        idle(2'd3);
        @(negedge clk);
        chk("drop_r3", rd_data, 8'h11);

        // Reset in the middle of a swap
        wr(2'd1, 8'h0A);
        wr(2'd2, 8'h05);
        cycle(0, 3'b001, 3'b100, 0, 0, 2'd0, 8'h00, 2'd0);
        cycle(0, 3'b010, 3'b001, 0, 0, 2'd0, 8'h00, 2'd0);
        cycle(1, 3'b100, 3'b010, 1, 0, 2'd0, 8'h00, 2'd0);
        cycle(0, 3'b100, 3'b010, 0, 0, 2'd0, 8'h00, 2'd0);
        @(negedge clk);
        chk("rst_cnt", xfer_cnt, 8'd0);
        chk("rst_swapped", {7'd0, swapped}, 8'd0);
        idle(2'd2);
        @(negedge clk);
        chk("rst_r2", rd_data, 8'h00);

        // Counter saturation
        cycle(1, 3'b000, 3'b000, 0, 0, 2'd0, 8'h00, 2'd0);
        for (int i = 0; i < 300; i++) cycle(0, 3'b001, 3'b001, 0, 0, 2'd0, 8'h00, 2'd0);
        idle(2'd0);
        @(negedge clk);
        chk("sat_cnt", xfer_cnt, 8'd255);

        // Bus read and capture with no driver
        cycle(1, 3'b000, 3'b000, 0, 0, 2'd0, 8'h00, 2'd0);
        wr(2'd2, 8'h5A);
        cycle(0, 3'b010, 3'b000, 0, 0, 2'd0, 8'h00, 2'd0);
        @(negedge clk);
        chk("read_bus", rd_data, 8'h5A);
        cycle(0, 3'b000, 3'b001, 0, 0, 2'd0, 8'h00, 2'd1);
        idle(2'd1);
        @(negedge clk);
        chk("nodrive_r1", rd_data, 8'h00);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            bit [3:1] h, c;
            for (int b = 1; b <= 3; b++) begin
                h[b] = ($urandom_range(99) < 30);
                c[b] = ($urandom_range(99) < 30);
            end
            if ($urandom_range(99) < 25) begin
                h = 3'b000;
                c = 3'b000;
            end
            cycle($urandom_range(99) < 3, h, c, $urandom_range(99) < 10,
                  $urandom_range(99) < 25, 2'($urandom_range(3)), 8'($urandom),
                  2'($urandom_range(3)));
        end
        idle(2'd0);
        idle(2'd0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
